// File: rtl/led_event_driver.sv
// led_event_driver
//
// Turns single-cycle event pulses into LED blinks that a person can see.
// Each event gives one blink: ON for ON_COUNTS cycles, then a mandatory OFF
// gap of OFF_COUNTS cycles. Events that arrive while a blink is running are
// queued (up to QUEUE_MAX) and played back to back. If the queue is full, the
// event is dropped and the sticky overflow flag is set.
//
// Handshake: event_in and clear_in are fire-and-forget pulses. There is no
// ready signal. Each cycle in which one of them is high counts as one request.
// The block always accepts event_in: it queues the event, starts a blink, or
// drops it and sets overflow. clear_in wins over a simultaneous event_in.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   event_in   one-cycle event pulse, one blink per pulse
//   clear_in   one-cycle request to flush the queue and clear overflow
//   led_out    registered LED pin drive
//   busy       high while a blink (ON or OFF phase) is in progress
//   pending    number of queued events not yet started
//   overflow   sticky: an event was dropped because the queue was full
//   state_dbg  current FSM state (0 idle, 1 on, 2 off), for checkers
//
// Build option: define LED_ACTIVE_LOW_EN for sinking LEDs. led_out is then
// inverted (0 = lit) and resets to 1. Nothing else changes.

module led_event_driver #(
  parameter int ON_COUNTS  = 12500000,
  parameter int OFF_COUNTS = 12500000,
  parameter int QUEUE_MAX  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       event_in,
  input  logic       clear_in,
  output logic       led_out,
  output logic       busy,
  output logic [3:0] pending,
  output logic       overflow,
  output logic [1:0] state_dbg
);

`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_LIT = 1'b0;
`else
  localparam logic LED_LIT = 1'b1;
`endif

  localparam logic [23:0] ON_LAST  = 24'(ON_COUNTS - 1);
  localparam logic [23:0] OFF_LAST = 24'(OFF_COUNTS - 1);
  localparam logic [3:0]  Q_FULL   = 4'(QUEUE_MAX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t      state;
  logic [23:0] timer;

  logic has_pend;
  logic on_done;
  logic off_done;
  logic start_idle;
  logic start_next;
  logic consume;
  logic inc;

  assign has_pend = (pending != 4'd0);
  assign on_done  = (state == S_ON)  && (timer == ON_LAST);
  assign off_done = (state == S_OFF) && (timer == OFF_LAST);

  // A flush suppresses every blink start in the cycle it is asserted.
  assign start_idle = (state == S_IDLE) && !clear_in && (event_in || has_pend);
  assign start_next = off_done && has_pend && !clear_in;

  // Consume takes a queued entry. An event that arrives with an empty queue in
  // IDLE starts its blink directly and never passes through the queue.
  assign consume = ((state == S_IDLE) && has_pend && !clear_in) || start_next;
  assign inc     = event_in && !clear_in && ((state != S_IDLE) || has_pend);

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      timer    <= 24'd0;
      led_out  <= ~LED_LIT;
      busy     <= 1'b0;
      pending  <= 4'd0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_idle) begin
            state   <= S_ON;
            timer   <= 24'd0;
            led_out <= LED_LIT;
            busy    <= 1'b1;
          end
        end
        S_ON: begin
          if (on_done) begin
            state   <= S_OFF;
            timer   <= 24'd0;
            led_out <= ~LED_LIT;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        S_OFF: begin
          if (off_done) begin
            timer <= 24'd0;
            if (start_next) begin
              state   <= S_ON;
              led_out <= LED_LIT;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 24'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          timer   <= 24'd0;
          led_out <= ~LED_LIT;
          busy    <= 1'b0;
        end
      endcase

      // Queue bookkeeping. An increment and a consume in the same cycle cancel
      // out, so a full queue can still take an event when one leaves.
      if (clear_in) begin
        pending  <= 4'd0;
        overflow <= 1'b0;
      end else if (inc && !consume) begin
        if (pending >= Q_FULL) begin
          overflow <= 1'b1;
        end else begin
          pending <= pending + 4'd1;
        end
      end else if (consume && !inc) begin
        pending <= pending - 4'd1;
      end
    end
  end

endmodule

// File: doc/led_event_driver.md
# led_event_driver

Output-side counterpart to the switch debouncer: it turns clean single-cycle event pulses from core logic into human-visible LED blinks on a physical pin. Each event produces one blink with a fixed ON time and a fixed OFF gap. Events that arrive during a blink are queued and played back to back. The block sits between game/control logic and the board LED pins.

## Interface
- `ON_COUNTS`, default 12500000: LED ON duration in clk cycles (250 ms at 50 MHz); legal range 1..2^24-1
- `OFF_COUNTS`, default 12500000: mandatory OFF gap after each blink, in clk cycles; legal range 1..2^24-1
- `QUEUE_MAX`, default 15: maximum queued (not-yet-started) events; legal range 1..15
- `clk` input 1: system clock, 50 MHz
- `rst_n` input 1: synchronous, active-low reset
- `event_in` input 1: single-cycle event pulse, e.g. a debounced `switch_pressed`
- `clear_in` input 1: single-cycle request to flush the queue and clear overflow
- `led_out` output 1: registered LED pin drive
- `busy` output 1: high whenever a blink (ON or OFF phase) is in progress
- `pending` output 4: number of queued events not yet started
- `overflow` output 1: sticky flag, set when an event is dropped because the queue is full

## Operation
- States: IDLE, ON, OFF. One 24-bit phase timer; one 4-bit pending counter.
- IDLE:
  - If `event_in`=1 or `pending`>0, go to ON with timer=0.
  - An event arriving in IDLE starts immediately and is never counted in `pending`.
  - With `pending`>0, starting the blink decrements `pending`.
- ON: timer increments each cycle. At timer=ON_COUNTS-1, go to OFF with timer=0.
- OFF: timer increments each cycle. At timer=OFF_COUNTS-1:
  - if `pending`>0, go to ON, timer=0, `pending`−1;
  - otherwise go to IDLE.
- Queueing:
  - `event_in` in ON or OFF increments `pending`.
  - `event_in` in IDLE with `pending`>0 also increments it.
  - If an increment and a consume (blink start) fall in the same cycle, `pending` is unchanged.
- Full queue:
  - An event arriving with `pending`=QUEUE_MAX and no simultaneous consume is dropped, and `overflow` is set.
  - `overflow` stays set until `clear_in` or reset.
- `clear_in`:
  - Sets `pending`=0 and `overflow`=0 on the next edge.
  - The blink in progress completes its ON and OFF phases, then returns to IDLE.
  - `clear_in` has priority over a simultaneous `event_in`; that event is discarded, and no blink starts from IDLE.
- Outputs:
  - `led_out`=1 exactly when state=ON.
  - `busy`=1 when state≠IDLE.

## Timing
- Reset values: state IDLE, timer 0, `pending` 0, `overflow` 0, `busy` 0, `led_out` inactive (0; 1 under the macro below).
- Reset mid-blink aborts the blink: all outputs take their reset values on the edge where `rst_n`=0 is sampled.
- Latency: `event_in` high at cycle t with the block idle and the queue empty gives `led_out`/`busy` high from cycle t+1.
- ON lasts exactly ON_COUNTS cycles; OFF lasts exactly OFF_COUNTS cycles. Back-to-back blink period is ON_COUNTS+OFF_COUNTS.
- `pending` and `overflow` update one cycle after the causing input.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `LED_ACTIVE_LOW_EN`:
  - Defined: `led_out` is inverted (0 = lit) and resets to 1, for boards with sinking LEDs.
  - Undefined: `led_out` is active-high and resets to 0.
  - Neither case changes `busy`, `pending`, `overflow`, or any timing.

## Test plan
All scenarios use ON_COUNTS=4, OFF_COUNTS=3, QUEUE_MAX=3, with the macro undefined.
- Reset: hold `rst_n`=0 for 2 cycles with `event_in` toggling -> `led_out`=0, `busy`=0, `pending`=0, `overflow`=0 throughout.
- Single event at cycle 10 -> `led_out`=1 in cycles 11–14 and 0 in 15–17; `busy`=1 in 11–17; IDLE and `busy`=0 at 18.
- Events at cycles 10, 11, 12:
  - `pending` reads 1 at 12 and 2 at 13, then 1 at 18 and 0 at 25.
  - `led_out`=1 in 11–14, 18–21 and 25–28.
  - `busy` falls at 32.
- Events at cycles 10–14:
  - `pending` saturates at 3.
  - The event at 14 is dropped, and `overflow`=1 from cycle 15.
  - Exactly 4 blinks occur.
  - `clear_in` at 40 sets `overflow`=0 at 41.
- `clear_in` at cycle 12 with `pending`=2, plus a simultaneous `event_in`:
  - `pending`=0 at 13.
  - The current blink finishes (`led_out` 11–14); `busy`=0 at 18.
  - No further blinks occur.
- `rst_n`=0 at cycle 13, during ON with `pending`=1 -> `led_out`=0, `busy`=0 and `pending`=0 at 14, and no blink resumes after reset is released.
